// File: rtl/control_unit_mc.sv
// Multi-cycle control unit for the K&S processor: fetch/decode sequencer with
// configurable RAM wait states and a selectable overflow source for BOV/BNOV.

package k_and_s_pkg;
    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_HALT   = 5'd15
    } decoded_instruction_type;
endpackage

module control_unit_mc
    import k_and_s_pkg::*;
#(
    parameter int MEM_WAIT    = 0,
    parameter int OV_UNSIGNED = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    write_reg_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt
);

    localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LAST  = CW'(MEM_WAIT);
    localparam logic [CW-1:0] WAIT_LAST1 = CW'(MEM_WAIT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_LATCH_IR,
        S_DECODE,
        S_LOAD_WAIT,
        S_LOAD_WB,
        S_STORE_WR,
        S_ALU_WB,
        S_HALTED
    } state_t;

    state_t      state_reg;
    logic [CW-1:0] cnt_reg;
    logic [1:0]  op_reg;

    logic [1:0]  dec_op;
    logic        taken;
    logic        ov_flag;

    // ALU op and branch condition straight from the current decode; only
    // consumed in DECODE (op is also captured there for ALU_WB).
    always_comb begin
        ov_flag = (OV_UNSIGNED != 0) ? unsigned_overflow : signed_overflow;
        dec_op  = 2'b00;
        taken   = 1'b0;
        case (decoded_instruction)
            I_SUB:         dec_op = 2'b01;
            I_AND:         dec_op = 2'b10;
            I_OR, I_MOVE:  dec_op = 2'b11;
            I_BRANCH:      taken  = 1'b1;
            I_BZERO:       taken  = zero_op;
            I_BNZERO:      taken  = ~zero_op;
            I_BNEG:        taken  = neg_op;
            I_BNNEG:       taken  = ~neg_op;
            I_BOV:         taken  = ov_flag;
            I_BNOV:        taken  = ~ov_flag;
            default:       ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
            cnt_reg   <= '0;
            op_reg    <= 2'b00;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (cnt_reg < WAIT_LAST) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end else begin
                        state_reg <= S_LATCH_IR;
                        cnt_reg   <= '0;
                    end
                end
                S_LATCH_IR: begin
                    state_reg <= S_DECODE;
                    cnt_reg   <= '0;
                end
                S_DECODE: begin
                    op_reg  <= dec_op;
                    cnt_reg <= '0;
                    case (decoded_instruction)
                        I_LOAD:  state_reg <= (MEM_WAIT > 0) ? S_LOAD_WAIT : S_LOAD_WB;
                        I_STORE: state_reg <= S_STORE_WR;
                        I_ADD, I_SUB, I_AND, I_OR: state_reg <= S_ALU_WB;
                        I_HALT:  state_reg <= S_HALTED;
                        default: state_reg <= S_FETCH;
                    endcase
                end
                S_LOAD_WAIT: begin
                    if (cnt_reg == WAIT_LAST1) begin
                        state_reg <= S_LOAD_WB;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_STORE_WR: begin
                    if (cnt_reg == WAIT_LAST) begin
                        state_reg <= S_FETCH;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_LOAD_WB, S_ALU_WB: begin
                    state_reg <= S_FETCH;
                    cnt_reg   <= '0;
                end
                S_HALTED: cnt_reg <= '0;
                default: begin
                    state_reg <= S_FETCH;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // Strobes are decoded from state so that a rising rst kills them at once.
    always_comb begin
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        write_reg_enable = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = 2'b00;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;
        if (!rst) begin
            case (state_reg)
                S_LATCH_IR: begin
                    ir_enable = 1'b1;
                    pc_enable = 1'b1;
                end
                S_DECODE: begin
                    case (decoded_instruction)
                        I_LOAD, I_STORE: addr_sel = 1'b1;
                        I_MOVE: begin
                            operation        = dec_op;
                            c_sel            = 1'b1;
                            write_reg_enable = 1'b1;
                        end
                        I_ADD, I_SUB, I_AND, I_OR: operation = dec_op;
                        default: ;
                    endcase
                    if (taken) begin
                        branch    = 1'b1;
                        pc_enable = 1'b1;
                    end
                end
                S_LOAD_WAIT: addr_sel = 1'b1;
                S_LOAD_WB: begin
                    addr_sel         = 1'b1;
                    write_reg_enable = 1'b1;
                end
                S_STORE_WR: begin
                    addr_sel         = 1'b1;
                    ram_write_enable = 1'b1;
                end
                S_ALU_WB: begin
                    operation        = op_reg;
                    c_sel            = 1'b1;
                    write_reg_enable = 1'b1;
                    flags_reg_enable = 1'b1;
                end
                S_HALTED: halt = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit_mc.sv
// Bench for control_unit_mc: three instances with different wait/overflow
// settings, each checked cycle by cycle against a per-instruction timeline model.

module tb_control_unit_mc;
    import k_and_s_pkg::*;

    localparam int NI = 3;
    localparam int W_TAB  [NI] = '{0, 2, 3};
    localparam int OV_TAB [NI] = '{0, 0, 1};

    localparam logic [10:0] B_BR = 11'h001;
    localparam logic [10:0] B_PC = 11'h002;
    localparam logic [10:0] B_IR = 11'h004;
    localparam logic [10:0] B_WR = 11'h008;
    localparam logic [10:0] B_AD = 11'h010;
    localparam logic [10:0] B_CS = 11'h020;
    localparam logic [10:0] B_FL = 11'h100;
    localparam logic [10:0] B_RW = 11'h200;
    localparam logic [10:0] B_HL = 11'h400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]           rst_v;
    decoded_instruction_type instr_v [NI];
    logic [NI-1:0]           z_v, n_v, uo_v, so_v;
    logic [NI-1:0][10:0]     obus;

    int passed = 0;
    int total  = 0;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            logic       branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel;
            logic [1:0] operation;
            logic       flags_reg_enable, ram_write_enable, halt;
            control_unit_mc #(
                .MEM_WAIT   (W_TAB[gi]),
                .OV_UNSIGNED(OV_TAB[gi])
            ) u_dut (
                .clk                (clk),
                .rst                (rst_v[gi]),
                .decoded_instruction(instr_v[gi]),
                .zero_op            (z_v[gi]),
                .neg_op             (n_v[gi]),
                .unsigned_overflow  (uo_v[gi]),
                .signed_overflow    (so_v[gi]),
                .branch             (branch),
                .pc_enable          (pc_enable),
                .ir_enable          (ir_enable),
                .write_reg_enable   (write_reg_enable),
                .addr_sel           (addr_sel),
                .c_sel              (c_sel),
                .operation          (operation),
                .flags_reg_enable   (flags_reg_enable),
                .ram_write_enable   (ram_write_enable),
                .halt               (halt)
            );
            assign obus[gi] = {halt, ram_write_enable, flags_reg_enable, operation,
                               c_sel, addr_sel, write_reg_enable, ir_enable, pc_enable, branch};
        end
    endgenerate

    function automatic logic [10:0] op_bits(input int op);
        return 11'(op) << 6;
    endfunction

    // Expected output per cycle of one instruction, from its first FETCH cycle.
    function automatic void model_seq(input int w, input int ov, input decoded_instruction_type ins,
                                      input logic z, input logic n, input logic uo, input logic so,
                                      output logic [10:0] q[$]);
        logic ovf;
        logic t;
        int   opn;
        q = {};
        for (int i = 0; i <= w; i++) q.push_back(11'h000);
        q.push_back(B_IR | B_PC);
        ovf = (ov != 0) ? uo : so;
        case (ins)
            I_LOAD: begin
                q.push_back(B_AD);
                for (int i = 0; i < w; i++) q.push_back(B_AD);
                q.push_back(B_AD | B_WR);
            end
            I_STORE: begin
                q.push_back(B_AD);
                for (int i = 0; i <= w; i++) q.push_back(B_AD | B_RW);
            end
            I_MOVE: q.push_back(op_bits(3) | B_CS | B_WR);
            I_ADD, I_SUB, I_AND, I_OR: begin
                opn = (ins == I_SUB) ? 1 : (ins == I_AND) ? 2 : (ins == I_OR) ? 3 : 0;
                q.push_back(op_bits(opn));
                q.push_back(op_bits(opn) | B_CS | B_WR | B_FL);
            end
            I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
                t = (ins == I_BRANCH) || (ins == I_BZERO && z) || (ins == I_BNZERO && !z) ||
                    (ins == I_BNEG && n) || (ins == I_BNNEG && !n) ||
                    (ins == I_BOV && ovf) || (ins == I_BNOV && !ovf);
                q.push_back(t ? (B_BR | B_PC) : 11'h000);
            end
            I_HALT: begin
                q.push_back(11'h000);
                for (int i = 0; i < 22; i++) q.push_back(B_HL);
            end
            default: q.push_back(11'h000);
        endcase
    endfunction

    task automatic set_in(input int k, input decoded_instruction_type ins,
                          input logic z, input logic n, input logic uo, input logic so);
        instr_v[k] = ins;
        z_v[k] = z; n_v[k] = n; uo_v[k] = uo; so_v[k] = so;
    endtask

    // Entered just after a rising edge; samples on each falling edge.
    task automatic run_cycles(input int k, input int n, output logic [10:0] obs[$]);
        obs = {};
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs.push_back(obus[k]);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut(input int k);
        rst_v[k] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_v[k] = 1'b0;
    endtask

    task automatic test_reset;
        logic [10:0] obs[$];
        set_in(0, I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_v[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (obus[0] !== 11'h000) $display("FAIL rst_init cyc %0d: got %b want 0", i, obus[0]);
            else passed++;
        end
        @(posedge clk); #1;
        rst_v[0] = 1'b0;
        run_cycles(0, 3, obs);
        total++;
        if (obs[1] !== (B_IR | B_PC) || obs[0] !== 11'h000 || obs[2] !== 11'h000)
            $display("FAIL rst_first_fetch: got %b %b %b want 0 %b 0", obs[0], obs[1], obs[2], B_IR | B_PC);
        else passed++;
        @(negedge clk);
        total++;
        if (obus[0] !== (B_CS | B_WR | B_FL)) $display("FAIL alu_wb_pre_rst: got %b want %b", obus[0], B_CS | B_WR | B_FL);
        else passed++;
        rst_v[0] = 1'b1;
        #1;
        total++;
        if (obus[0] !== 11'h000) $display("FAIL rst_mid_alu_wb: got %b want 0", obus[0]);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            total++;
            if (obus[0] !== 11'h000) $display("FAIL rst_hold cyc %0d: got %b want 0", i, obus[0]);
            else passed++;
        end
        @(posedge clk); #1;
        rst_v[0] = 1'b0;
        run_cycles(0, 2, obs);
        total++;
        if (obs[0] !== 11'h000 || obs[1] !== (B_IR | B_PC))
            $display("FAIL rst_release: got %b %b want 0 %b", obs[0], obs[1], B_IR | B_PC);
        else passed++;
        $display("reset test done");
    endtask

    task automatic test_nop_stream;
        logic [10:0] obs[$];
        logic        want_ir;
        reset_dut(2);
        set_in(2, I_NOP, 1'b1, 1'b1, 1'b1, 1'b1);
        run_cycles(2, 24, obs);
        for (int i = 0; i < 24; i++) begin
            want_ir = ((i % 6) == 4);
            total++;
            if (obs[i][2] !== want_ir || obs[i][4] !== 1'b0)
                $display("FAIL nop_stream cyc %0d: ir=%b addr=%b want ir=%b addr=0", i, obs[i][2], obs[i][4], want_ir);
            else passed++;
        end
        $display("nop stream: 24 cycles");
    endtask

    task automatic test_load;
        logic [10:0] exp[$];
        logic [10:0] obs[$];
        int          addr_cnt;
        reset_dut(1);
        set_in(1, I_LOAD, 1'b0, 1'b0, 1'b0, 1'b0);
        model_seq(W_TAB[1], OV_TAB[1], I_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, exp);
        run_cycles(1, exp.size(), obs);
        addr_cnt = 0;
        for (int i = 0; i < exp.size(); i++) begin
            addr_cnt += int'(obs[i][4]);
            total++;
            if (obs[i] !== exp[i]) $display("FAIL load cyc %0d: got %b want %b", i, obs[i], exp[i]);
            else passed++;
        end
        total++;
        if (addr_cnt !== 4 || exp.size() != 8) $display("FAIL load_addr_cycles: got %0d want 4", addr_cnt);
        else passed++;
        $display("load: %0d cycles", exp.size());
    endtask

    task automatic test_store;
        logic [10:0] exp[$];
        logic [10:0] obs[$];
        reset_dut(1);
        set_in(1, I_STORE, 1'b0, 1'b0, 1'b0, 1'b0);
        model_seq(W_TAB[1], OV_TAB[1], I_STORE, 1'b0, 1'b0, 1'b0, 1'b0, exp);
        run_cycles(1, exp.size(), obs);
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (obs[i] !== exp[i]) $display("FAIL store cyc %0d: got %b want %b", i, obs[i], exp[i]);
            else passed++;
        end
        run_cycles(1, 6, obs);
        total++;
        if (obs[5] !== (B_AD | B_RW)) $display("FAIL store_wr1: got %b want %b", obs[5], B_AD | B_RW);
        else passed++;
        rst_v[1] = 1'b1;
        #1;
        total++;
        if (obus[1] !== 11'h000) $display("FAIL store_rst_same_cycle: got %b want 0", obus[1]);
        else passed++;
        @(posedge clk); #1;
        rst_v[1] = 1'b0;
        set_in(1, I_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        model_seq(W_TAB[1], OV_TAB[1], I_NOP, 1'b0, 1'b0, 1'b0, 1'b0, exp);
        run_cycles(1, exp.size(), obs);
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (obs[i] !== exp[i]) $display("FAIL store_abort_restart cyc %0d: got %b want %b", i, obs[i], exp[i]);
            else passed++;
        end
        $display("store: full write then aborted write");
    endtask

    task automatic test_sub_bzero;
        logic [10:0] exp[$];
        logic [10:0] obs[$];
        decoded_instruction_type seq_i [3] = '{I_SUB, I_BZERO, I_BZERO};
        logic                    seq_z [3] = '{1'b0, 1'b1, 1'b0};
        reset_dut(0);
        for (int s = 0; s < 3; s++) begin
            set_in(0, seq_i[s], seq_z[s], 1'b0, 1'b0, 1'b0);
            model_seq(W_TAB[0], OV_TAB[0], seq_i[s], seq_z[s], 1'b0, 1'b0, 1'b0, exp);
            run_cycles(0, exp.size(), obs);
            for (int i = 0; i < exp.size(); i++) begin
                total++;
                if (obs[i] !== exp[i]) $display("FAIL sub_bzero step %0d cyc %0d: got %b want %b", s, i, obs[i], exp[i]);
                else passed++;
            end
            $display("sub/bzero step %0d: %s z=%b", s, seq_i[s].name(), seq_z[s]);
        end
    endtask

    task automatic test_bov_halt;
        logic [10:0] exp[$];
        logic [10:0] obs[$];
        for (int s = 0; s < 2; s++) begin
            int k;
            k = (s == 0) ? 2 : 0;
            reset_dut(k);
            set_in(k, I_BOV, 1'b0, 1'b0, 1'b0, 1'b1);
            model_seq(W_TAB[k], OV_TAB[k], I_BOV, 1'b0, 1'b0, 1'b0, 1'b1, exp);
            run_cycles(k, exp.size(), obs);
            total++;
            if (obs[exp.size()-1] !== ((s == 0) ? 11'h000 : (B_BR | B_PC)))
                $display("FAIL bov_decode ov_unsigned=%0d: got %b", OV_TAB[k], obs[exp.size()-1]);
            else passed++;
            for (int i = 0; i < exp.size(); i++) begin
                total++;
                if (obs[i] !== exp[i]) $display("FAIL bov ov_unsigned=%0d cyc %0d: got %b want %b", OV_TAB[k], i, obs[i], exp[i]);
                else passed++;
            end
            $display("bov ov_unsigned=%0d checked", OV_TAB[k]);
        end
        set_in(0, I_HALT, 1'b0, 1'b0, 1'b0, 1'b0);
        model_seq(W_TAB[0], OV_TAB[0], I_HALT, 1'b0, 1'b0, 1'b0, 1'b0, exp);
        run_cycles(0, exp.size(), obs);
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (obs[i] !== exp[i]) $display("FAIL halt cyc %0d: got %b want %b", i, obs[i], exp[i]);
            else passed++;
        end
        for (int i = 0; i < 5; i++) begin
            set_in(0, decoded_instruction_type'(5'($urandom_range(0, 14))), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            @(negedge clk);
            total++;
            if (obus[0] !== B_HL) $display("FAIL halt_sticky cyc %0d: got %b want %b", i, obus[0], B_HL);
            else passed++;
            @(posedge clk); #1;
        end
        $display("halt held");
    endtask

    task automatic test_random;
        logic [10:0] exp[$];
        logic [10:0] obs[$];
        decoded_instruction_type ins;
        logic z, n, uo, so;
        int   r;
        for (int k = 0; k < NI; k++) begin
            reset_dut(k);
            for (int t = 0; t < 25; t++) begin
                r = $urandom_range(0, 19);
                ins = (r == 15) ? I_NOP : decoded_instruction_type'(5'(r));
                z = 1'($urandom); n = 1'($urandom); uo = 1'($urandom); so = 1'($urandom);
                set_in(k, ins, z, n, uo, so);
                model_seq(W_TAB[k], OV_TAB[k], ins, z, n, uo, so, exp);
                run_cycles(k, exp.size(), obs);
                for (int i = 0; i < exp.size(); i++) begin
                    total++;
                    if (obs[i] !== exp[i])
                        $display("FAIL random dut %0d instr %0d (%0d) cyc %0d: got %b want %b", k, t, r, i, obs[i], exp[i]);
                    else passed++;
                end
                $display("random dut %0d instr %0d code %0d flags z%b n%b uo%b so%b", k, t, r, z, n, uo, so);
            end
        end
    endtask

    initial begin
        rst_v = '1;
        z_v = '0; n_v = '0; uo_v = '0; so_v = '0;
        for (int k = 0; k < NI; k++) instr_v[k] = I_NOP;
        test_reset;
        test_nop_stream;
        test_load;
        test_store;
        test_sub_bzero;
        test_bov_halt;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
